// File: rtl/gpio_port_if.sv
// rtl/gpio_port_if.sv - register bus between the processor and gpio_port
interface gpio_port_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             irq;

    modport master (
        output addr, wr_en, wr_data, rd_en,
        input  rd_data, irq
    );

    modport slave (
        input  addr, wr_en, wr_data, rd_en,
        output rd_data, irq
    );
endinterface

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - register-mapped GPIO with synchronised, debounced inputs and edge interrupts
module gpio_port #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpi,
    output logic [WIDTH-1:0] gpo,
    gpio_port_if.slave       bus
);

    localparam logic [2:0] ADDR_IN      = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_RISE_EN = 3'd2;
    localparam logic [2:0] ADDR_FALL_EN = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_OUT_SET = 3'd5;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd6;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpi;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb_next = sync;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt      [WIDTH];
            logic [CNT_W-1:0] cnt_next [WIDTH];

            // Any cycle where sync agrees with deb restarts the run, so short glitches never land.
            always_comb begin
                deb_next = deb;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_next[i] = '0;
                    if (sync[i] != deb[i]) begin
                        if (cnt[i] == CNT_LAST) begin
                            deb_next[i] = sync[i];
                        end else begin
                            cnt_next[i] = cnt[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (reset) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt_next[i];
                    end
                end
            end
        end
    endgenerate

    // Edge flags are set from deb_next so they land on the same edge as deb; set beats clear.
    always_comb begin
        status_clr = '0;
        if (bus.wr_en && (bus.addr == ADDR_STATUS)) begin
            status_clr = bus.wr_data;
        end
        status_next = (status & ~status_clr)
                    | (deb_next & ~deb & rise_en)
                    | (~deb_next & deb & fall_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpo     <= OUT_RESET;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            deb     <= '0;
        end else begin
            deb    <= deb_next;
            status <= status_next;
            if (bus.wr_en) begin
                case (bus.addr)
                    ADDR_OUT:     gpo     <= bus.wr_data;
                    ADDR_RISE_EN: rise_en <= bus.wr_data;
                    ADDR_FALL_EN: fall_en <= bus.wr_data;
                    ADDR_OUT_SET: gpo     <= gpo | bus.wr_data;
                    ADDR_OUT_CLR: gpo     <= gpo & ~bus.wr_data;
                    default:      ;
                endcase
            end
        end
    end

    // Read mux uses the registered values, so a same-cycle write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (bus.rd_en) begin
            case (bus.addr)
                ADDR_IN:      rd_q <= deb;
                ADDR_OUT:     rd_q <= gpo;
                ADDR_RISE_EN: rd_q <= rise_en;
                ADDR_FALL_EN: rd_q <= fall_en;
                ADDR_STATUS:  rd_q <= status;
                default:      rd_q <= '0;
            endcase
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.irq     = |status;

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - directed self-checking bench for gpio_port
module tb_gpio_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpi;
    logic [7:0] gpo;
    int         passed = 0;
    int         total  = 0;
    logic [7:0] v;

    gpio_port_if #(.WIDTH(8)) bus ();

    gpio_port #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .OUT_RESET(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gpi(gpi),
        .gpo(gpo),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    initial begin
        reset       = 1'b1;
        gpi         = 8'h00;
        bus.addr    = 3'd0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: reset state and output writes
        check("reset_gpo", gpo, 8'h00);
        check("reset_rd_data", bus.rd_data, 8'h00);
        check("reset_irq", {7'd0, bus.irq}, 8'h00);
        wr(3'd1, 8'hA5);
        check("out_write", gpo, 8'hA5);
        wr(3'd5, 8'h0F);
        check("out_set", gpo, 8'hAF);
        wr(3'd6, 8'h81);
        check("out_clr", gpo, 8'h2E);
        rd(3'd1, v);
        check("out_readback", v, 8'h2E);

        // 2: input latency; read at sampling edge E0..E5 sees old deb, E6 sees new
        gpi = 8'h01;
        for (int k = 0; k < 6; k++) begin
            rd(3'd0, v);
            check($sformatf("in_latency_pre_%0d", k), v, 8'h00);
        end
        rd(3'd0, v);
        check("in_latency_first", v, 8'h01);
        gpi = 8'h00;
        for (int k = 0; k < 8; k++) step();
        rd(3'd0, v);
        check("in_back_low", v, 8'h00);

        // 3: glitch reject (3 cycles), then a 4-cycle pulse that is accepted
        gpi = 8'h08;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) gpi = 8'h00;
            rd(3'd0, v);
            check($sformatf("glitch3_in_%0d", k), v, 8'h00);
        end
        rd(3'd4, v);
        check("glitch3_status", v, 8'h00);
        for (int k = 0; k < 11; k++) begin
            gpi = (k < 4) ? 8'h08 : 8'h00;
            rd(3'd0, v);
            check($sformatf("pulse4_in_%0d", k), v, (k >= 6 && k <= 9) ? 8'h08 : 8'h00);
        end

        // 4: edge interrupt
        wr(3'd2, 8'h01);
        wr(3'd3, 8'h02);
        gpi = 8'h03;
        for (int k = 0; k < 8; k++) step();
        rd(3'd4, v);
        check("edge_rise_status", v, 8'h01);
        check("edge_rise_irq", {7'd0, bus.irq}, 8'h01);
        gpi = 8'h00;
        for (int k = 0; k < 8; k++) step();
        rd(3'd4, v);
        check("edge_fall_status", v, 8'h03);
        check("edge_fall_irq", {7'd0, bus.irq}, 8'h01);
        wr(3'd4, 8'h01);
        rd(3'd4, v);
        check("w1c_bit0_status", v, 8'h02);
        check("w1c_bit0_irq", {7'd0, bus.irq}, 8'h01);
        wr(3'd4, 8'h02);
        check("w1c_bit1_irq", {7'd0, bus.irq}, 8'h00);
        rd(3'd4, v);
        check("w1c_bit1_status", v, 8'h00);

        // 5: clear of STATUS[0] on the same edge that bit0 rises
        gpi = 8'h01;
        for (int k = 0; k < 5; k++) step();
        wr(3'd4, 8'h01);
        rd(3'd4, v);
        check("set_beats_clear_status", v, 8'h01);
        check("set_beats_clear_irq", {7'd0, bus.irq}, 8'h01);
        wr(3'd4, 8'hFF);
        rd(3'd4, v);
        check("clear_all_status", v, 8'h00);
        gpi = 8'h00;
        for (int k = 0; k < 8; k++) step();

        // 6: read/write collision, reserved reads, reset mid-debounce
        wr(3'd1, 8'h11);
        bus.addr    = 3'd1;
        bus.wr_data = 8'h3C;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        check("rw_collision_rd", bus.rd_data, 8'h11);
        check("rw_collision_gpo", gpo, 8'h3C);
        rd(3'd1, v);
        check("rw_collision_after", v, 8'h3C);
        rd(3'd7, v);
        check("reserved_addr7", v, 8'h00);
        wr(3'd1, 8'h5A);
        rd(3'd1, v);
        rd(3'd5, v);
        check("write_only_addr5", v, 8'h00);

        gpi = 8'h04;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        gpi   = 8'h00;
        step();
        reset = 1'b0;
        check("midreset_gpo", gpo, 8'h00);
        check("midreset_irq", {7'd0, bus.irq}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            rd(3'd0, v);
            check($sformatf("midreset_in_%0d", k), v, 8'h00);
        end
        rd(3'd2, v);
        check("midreset_rise_en", v, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
